hw_sensor_arbiter: RTL
======================

# hw_sensor_arbiter

Packet-locked round-robin arbiter sharing the single voltage/temperature sensor command/response stream pair between several requesters, e.g. the hardware monitor sequencer and a software-driven mailbox path. Each requester owns the sensor from its command start-of-packet until the matching response end-of-packet. Responses are routed back only to the granted requester. An optional response watchdog releases the sensor if the response never completes.

## Interface
- P_NUM_REQ, 2: number of requesters, 2..8.
- P_DATA_WIDTH, 32: command and response data width.
- P_RSP_TIMEOUT, 4096: watchdog limit in clk cycles between accepted response beats; must be ≥2. Used only with the macro.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset: 0 resets, release is synchronous to clk.
- req_cmd_valid_i / req_cmd_startofpacket_i / req_cmd_endofpacket_i  in  P_NUM_REQ  per-requester command qualifiers.
- req_cmd_data_i  in  P_NUM_REQ×P_DATA_WIDTH  per-requester command data, packed.
- req_cmd_ready_o  out  P_NUM_REQ  per-requester command ready.
- req_rsp_valid_o / req_rsp_startofpacket_o / req_rsp_endofpacket_o  out  P_NUM_REQ  routed response qualifiers.
- req_rsp_data_o  out  P_DATA_WIDTH  response data, broadcast to all requesters and qualified by valid.
- req_rsp_ready_i  in  P_NUM_REQ  per-requester response ready.
- command_valid_o, command_data_o[P_DATA_WIDTH], command_startofpacket_o, command_endofpacket_o  out  sensor command stream.
- command_ready_i  in  1  sensor command ready.
- response_valid_i, response_data_i[P_DATA_WIDTH], response_startofpacket_i, response_endofpacket_i  in  sensor response stream.
- response_ready_o  out  1  sensor response ready.
- grant_o  out  GW = max(1, clog2(P_NUM_REQ))  index of the current owner.
- busy_o  out  1  high when the state is not IDLE.
- timeout_o  out  1  one-cycle pulse on watchdog expiry (macro only; otherwise tied to 0).
- drop_count_o  out  16  saturating count of discarded stray response beats (macro only; otherwise tied to 0).

## Operation
- States: IDLE, CMD, RSP.
- IDLE: no command or response path is connected. If any req_cmd_valid_i bit is high, grant the first requester at or after rr_ptr, searching cyclically upward. Register grant_o and go to CMD.
- CMD: the command stream is a combinational pass-through from the granted requester. command_* is driven from the granted req_cmd_*, and req_cmd_ready_o[g] = command_ready_i. All other ready bits are 0. An accepted beat (valid & ready) with endofpacket moves the state to RSP.
- RSP: the response stream is routed to the granted requester. req_rsp_valid_o[g] = response_valid_i, and response_ready_o = req_rsp_ready_i[g]. An accepted beat with endofpacket moves the state to IDLE and sets rr_ptr = (g+1) mod P_NUM_REQ.
- Requesters are never preempted. A requester that drops valid mid-packet holds the grant indefinitely.
- Response beats arriving in IDLE or CMD: response_ready_o = 0 (macro off).

## Timing
- Reset values: state IDLE, rr_ptr 0, grant_o 0, busy_o 0, timeout_o 0, drop_count_o 0. All ready and valid outputs are 0.
- Grant latency: 1 cycle. A request seen in IDLE at cycle n has its first command beat passable at n+1.
- Data path latency: zero-cycle combinational in both directions; no buffering.
- Single-beat command (sop and eop together): a valid & ready beat enters RSP on the next edge.
- Response-end to next grant: 1 cycle of IDLE is mandatory, so there is no back-to-back grant in the same cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N-1,0.
- Reset mid-packet: the arbiter returns to IDLE immediately. Any packet in flight is abandoned, and requesters must also be reset.

## Configuration
- Macro: HW_SENSOR_ARB_TIMEOUT_EN.
- When defined, a watchdog counter of width clog2(P_RSP_TIMEOUT+1) runs in RSP:
  - It clears on entry to RSP and on every accepted response beat, and increments otherwise.
  - At count P_RSP_TIMEOUT-1 the arbiter pulses timeout_o, goes to IDLE and advances rr_ptr as on normal completion.
  - In IDLE and CMD, response_ready_o = 1. Stray beats are discarded, and drop_count_o increments per beat, saturating at 0xFFFF.
- When undefined: no counter, timeout_o and drop_count_o are tied to 0, and stray responses back-pressure the sensor.

## Structure
- Package hw_sensor_arb_pkg holds:
  - the state enum typedef (IDLE, CMD, RSP);
  - the GW width function;
  - the drop-counter width constant (16).
- Sub-module hw_rr_pick: combinational round-robin picker with inputs req[P_NUM_REQ] and ptr[GW], and outputs grant index and any_req.
- The FSM, muxing and watchdog stay in hw_sensor_arbiter.

## Test plan
- Single requester 1 sends a 1-beat command 0x0000_0011, and the sensor returns a 2-beat response → grant_o=1 one cycle after valid; the response reaches requester 1 only; busy_o falls after the eop beat; rr_ptr=0 (with P_NUM_REQ=2).
- Both requesters continuously valid for 4 transactions → grant order is 0,1,0,1, with exactly one IDLE cycle between packets.
- Sensor holds command_ready_i=0 for 10 cycles mid-packet while requester 0 holds valid → grant is unchanged, no beats are lost, and requester 1 sees ready=0 throughout.
- Macro on, P_RSP_TIMEOUT=16, no response after the command eop → timeout_o pulses at the 16th RSP cycle and the next grant goes to requester 1. A late 3-beat response then arrives in IDLE → drop_count_o=3.
- Reset driven to 0 during RSP → all outputs return to their reset values within the same cycle, and after release a new request is granted normally.

Source files
------------

// File: rtl/hw_sensor_arb_pkg.sv
// Shared types and helpers for the sensor stream arbiter.
package hw_sensor_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RSP
    } arb_state_e;

    localparam int DROP_CNT_W = 16;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int grant_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/hw_sensor_arbiter_if.sv
// Sensor-side command/response stream pair shared by all requesters.
interface hw_sensor_arbiter_if #(
    parameter int P_DATA_WIDTH = 32
);

    logic                    command_valid;
    logic                    command_ready;
    logic [P_DATA_WIDTH-1:0] command_data;
    logic                    command_startofpacket;
    logic                    command_endofpacket;

    logic                    response_valid;
    logic                    response_ready;
    logic [P_DATA_WIDTH-1:0] response_data;
    logic                    response_startofpacket;
    logic                    response_endofpacket;

    modport master (
        output command_valid, command_data, command_startofpacket, command_endofpacket,
        input  command_ready,
        input  response_valid, response_data, response_startofpacket, response_endofpacket,
        output response_ready
    );

    modport slave (
        input  command_valid, command_data, command_startofpacket, command_endofpacket,
        output command_ready,
        output response_valid, response_data, response_startofpacket, response_endofpacket,
        input  response_ready
    );

endinterface

// File: rtl/hw_sensor_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically upward.
module hw_rr_pick
    import hw_sensor_arb_pkg::*;
#(
    parameter int P_NUM_REQ = 2,
    localparam int GW = grant_width(P_NUM_REQ)
) (
    input  logic [P_NUM_REQ-1:0] req,
    input  logic [GW-1:0]        ptr,
    output logic [GW-1:0]        grant,
    output logic                 any_req
);

    // Walk the offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant = '0;
        for (int i = P_NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % P_NUM_REQ]) begin
                grant = GW'((int'(ptr) + i) % P_NUM_REQ);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/hw_sensor_arbiter.sv
// Packet-locked round-robin arbiter for the shared sensor command/response streams.
// Optional response watchdog and stray-beat drop counter: HW_SENSOR_ARB_TIMEOUT_EN.
module hw_sensor_arbiter
    import hw_sensor_arb_pkg::*;
#(
    parameter int P_NUM_REQ     = 2,
    parameter int P_DATA_WIDTH  = 32,
    parameter int P_RSP_TIMEOUT = 4096,
    localparam int GW = grant_width(P_NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic [P_NUM_REQ-1:0]              req_cmd_valid_i,
    input  logic [P_NUM_REQ-1:0]              req_cmd_startofpacket_i,
    input  logic [P_NUM_REQ-1:0]              req_cmd_endofpacket_i,
    input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] req_cmd_data_i,
    output logic [P_NUM_REQ-1:0]              req_cmd_ready_o,

    output logic [P_NUM_REQ-1:0]              req_rsp_valid_o,
    output logic [P_NUM_REQ-1:0]              req_rsp_startofpacket_o,
    output logic [P_NUM_REQ-1:0]              req_rsp_endofpacket_o,
    output logic [P_DATA_WIDTH-1:0]           req_rsp_data_o,
    input  logic [P_NUM_REQ-1:0]              req_rsp_ready_i,

    hw_sensor_arbiter_if.master               sensor,

    output logic [GW-1:0]                     grant_o,
    output logic                              busy_o,
    output logic                              timeout_o,
    output logic [DROP_CNT_W-1:0]             drop_count_o
);

    arb_state_e state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] pick_grant;
    logic [GW-1:0] next_ptr;
    logic          any_req;
    logic          cmd_accept;
    logic          rsp_accept;
    logic          wdog_expire;

    logic [P_DATA_WIDTH-1:0] cmd_data_lane [P_NUM_REQ];

    for (genvar i = 0; i < P_NUM_REQ; i++) begin : g_lane
        assign cmd_data_lane[i] = req_cmd_data_i[i*P_DATA_WIDTH +: P_DATA_WIDTH];
    end

    hw_rr_pick #(
        .P_NUM_REQ (P_NUM_REQ)
    ) u_pick (
        .req     (req_cmd_valid_i),
        .ptr     (rr_ptr_q),
        .grant   (pick_grant),
        .any_req (any_req)
    );

    assign cmd_accept = (state_q == CMD) && req_cmd_valid_i[grant_q] && sensor.command_ready;
    assign rsp_accept = (state_q == RSP) && sensor.response_valid && req_rsp_ready_i[grant_q];
    assign next_ptr   = (grant_q == GW'(P_NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Ownership runs from the command SOP to the response EOP (or a watchdog expiry).
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;

        req_cmd_ready_o         = '0;
        req_rsp_valid_o         = '0;
        req_rsp_startofpacket_o = '0;
        req_rsp_endofpacket_o   = '0;

        sensor.command_valid         = 1'b0;
        sensor.command_data          = '0;
        sensor.command_startofpacket = 1'b0;
        sensor.command_endofpacket   = 1'b0;
        sensor.response_ready        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick_grant;
                    state_d = CMD;
                end
            end
            CMD: begin
                sensor.command_valid         = req_cmd_valid_i[grant_q];
                sensor.command_data          = cmd_data_lane[grant_q];
                sensor.command_startofpacket = req_cmd_startofpacket_i[grant_q];
                sensor.command_endofpacket   = req_cmd_endofpacket_i[grant_q];
                req_cmd_ready_o[grant_q]     = sensor.command_ready;
                if (cmd_accept && req_cmd_endofpacket_i[grant_q]) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                req_rsp_valid_o[grant_q]         = sensor.response_valid;
                req_rsp_startofpacket_o[grant_q] = sensor.response_startofpacket;
                req_rsp_endofpacket_o[grant_q]   = sensor.response_endofpacket;
                sensor.response_ready            = req_rsp_ready_i[grant_q];
                if ((rsp_accept && sensor.response_endofpacket) || wdog_expire) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef HW_SENSOR_ARB_TIMEOUT_EN
        // Outside RSP, stray responses are swallowed instead of stalling the sensor.
        if (state_q != RSP) begin
            sensor.response_ready = reset;
        end
`endif
    end

    assign req_rsp_data_o = sensor.response_data;
    assign grant_o        = grant_q;
    assign busy_o         = (state_q != IDLE);

`ifdef HW_SENSOR_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(P_RSP_TIMEOUT + 1);

    logic [WDW-1:0]        wdog_q;
    logic [DROP_CNT_W-1:0] drop_q;

    // Holding the counter at zero outside RSP gives a clean start on every RSP entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
            drop_q <= '0;
        end else begin
            if ((state_q != RSP) || rsp_accept) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_q + 1'b1;
            end
            if ((state_q != RSP) && sensor.response_valid && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign wdog_expire  = (state_q == RSP) && !rsp_accept && (wdog_q == WDW'(P_RSP_TIMEOUT - 1));
    assign timeout_o    = wdog_expire;
    assign drop_count_o = drop_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (P_RSP_TIMEOUT > 1);
    assign wdog_expire        = 1'b0;
    assign timeout_o          = 1'b0;
    assign drop_count_o       = '0;
`endif

endmodule
